// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared constants, state encoding and hole origin table
package whack_pkg;

  localparam int NUM_HOLES = 6;
  localparam int COLOUR_W  = 12;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Holes are laid out row-major, three per row.
  function automatic logic [7:0] hole_x(input logic [2:0] hole);
    case (hole)
      3'd0, 3'd3: hole_x = 8'd24;
      3'd1, 3'd4: hole_x = 8'd72;
      3'd2, 3'd5: hole_x = 8'd120;
      default:    hole_x = 8'd0;
    endcase
  endfunction

  function automatic logic [6:0] hole_y(input logic [2:0] hole);
    hole_y = (hole < 3'd3) ? 7'd40 : 7'd84;
  endfunction

endpackage

// File: rtl/mole_px_delay.sv
// rtl/mole_px_delay.sv - fixed-depth shift register aligning pixel tags with ROM data
module mole_px_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         iClock,
  input  logic         iResetn,
  input  logic [W-1:0] iData,
  output logic [W-1:0] oData
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= iData;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign oData = stage_q[DEPTH-1];

endmodule

// File: rtl/mole_sprite_drawer.sv
// rtl/mole_sprite_drawer.sv - sweeps one sprite tile at a hole, drawing ROM pixels or erasing to background
module mole_sprite_drawer
  import whack_pkg::*;
#(
  parameter int                   SPRITE_W    = 16,
  parameter int                   SPRITE_H    = 16,
  parameter int                   ROM_LAT     = 1,
  parameter logic [COLOUR_W-1:0]  TRANSPARENT = 12'hF0F,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR   = 12'h4A2
) (
  input  logic                                    iClock,
  input  logic                                    iResetn,
  input  logic                                    iStart,
  input  logic [2:0]                              iHole,
  input  logic                                    iErase,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]    oRomAddr,
  input  logic [COLOUR_W-1:0]                     iRomData,
  output logic [7:0]                              oX,
  output logic [6:0]                              oY,
  output logic [COLOUR_W-1:0]                     oColour,
  output logic                                    oPlot,
  output logic                                    oBusy,
  output logic                                    oDone
);

  localparam int         CX_W       = $clog2(SPRITE_W);
  localparam int         CY_W       = $clog2(SPRITE_H);
  localparam int         TAG_W      = 1 + 8 + 7;
  localparam logic [2:0] LAST_HOLE  = 3'(NUM_HOLES - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT);

  state_t            state_q, state_d;
  logic [CX_W-1:0]   cx_q, cx_d;
  logic [CY_W-1:0]   cy_q, cy_d;
  logic [7:0]        x0_q, x0_d;
  logic [6:0]        y0_q, y0_d;
  logic              erase_q, erase_d;
  logic [1:0]        drain_q, drain_d;

  logic [TAG_W-1:0]  tag_in, tag_out;
  logic              tag_valid;
  logic [7:0]        tag_x;
  logic [6:0]        tag_y;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    erase_d = erase_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          if (iHole <= LAST_HOLE) begin
            x0_d    = hole_x(iHole);
            y0_d    = hole_y(iHole);
            erase_d = iErase;
            cx_d    = '0;
            cy_d    = '0;
            state_d = ST_SWEEP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SWEEP: begin
        cx_d = cx_q + CX_W'(1);
        if (cx_q == '1) begin
          cy_d = cy_q + CY_W'(1);
          if (cy_q == '1) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      // One extra cycle beyond the ROM latency lets the last pixel leave the output register.
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == DRAIN_LAST) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q <= ST_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      erase_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      erase_q <= erase_d;
      drain_q <= drain_d;
    end
  end

  assign oRomAddr = {cy_q, cx_q};
  assign tag_in   = {(state_q == ST_SWEEP), x0_q + 8'(cx_q), y0_q + 7'(cy_q)};

  mole_px_delay #(
    .DEPTH (ROM_LAT),
    .W     (TAG_W)
  ) u_delay (
    .iClock  (iClock),
    .iResetn (iResetn),
    .iData   (tag_in),
    .oData   (tag_out)
  );

  assign {tag_valid, tag_x, tag_y} = tag_out;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
    end else if (tag_valid) begin
      oX      <= tag_x;
      oY      <= tag_y;
      oColour <= erase_q ? BG_COLOUR : iRomData;
      oPlot   <= erase_q | (iRomData != TRANSPARENT);
    end else begin
      oPlot   <= 1'b0;
    end
  end

  assign oBusy = (state_q != ST_IDLE);
  assign oDone = (state_q == ST_DONE);

endmodule

// File: tb/tb_mole_sprite_drawer.sv
// tb/tb_mole_sprite_drawer.sv - directed self-checking bench for mole_sprite_drawer
module tb_mole_sprite_drawer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, erase_a, plot_a, busy_a, done_a;
  logic [2:0]  hole_a;
  logic [7:0]  addr_a, x_a;
  logic [6:0]  y_a;
  logic [11:0] rom_a_q, col_a;

  logic        rst_b, start_b, erase_b, plot_b, busy_b, done_b;
  logic [2:0]  hole_b;
  logic [7:0]  addr_b, x_b;
  logic [6:0]  y_b;
  logic [11:0] rom_b_q1, rom_b_q2, col_b;

  int rom_mode_a = 0;
  int rom_mode_b = 0;

  mole_sprite_drawer u_dut_a (
    .iClock(clk), .iResetn(rst_a), .iStart(start_a), .iHole(hole_a), .iErase(erase_a),
    .oRomAddr(addr_a), .iRomData(rom_a_q), .oX(x_a), .oY(y_a), .oColour(col_a),
    .oPlot(plot_a), .oBusy(busy_a), .oDone(done_a)
  );

  mole_sprite_drawer #(.ROM_LAT(2)) u_dut_b (
    .iClock(clk), .iResetn(rst_b), .iStart(start_b), .iHole(hole_b), .iErase(erase_b),
    .oRomAddr(addr_b), .iRomData(rom_b_q2), .oX(x_b), .oY(y_b), .oColour(col_b),
    .oPlot(plot_b), .oBusy(busy_b), .oDone(done_b)
  );

  function automatic logic [11:0] rom_fn(input int mode, input logic [7:0] a);
    if (mode == 1) return (a < 8'd16) ? 12'hF0F : 12'hFFF;
    return 12'h00F;
  endfunction

  always @(posedge clk) begin
    rom_a_q  <= rom_fn(rom_mode_a, addr_a);
    rom_b_q1 <= rom_fn(rom_mode_b, addr_b);
    rom_b_q2 <= rom_b_q1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int n_plots, first_x, first_y, last_x, last_y, first_cyc, done_cyc;
  int order_err, colour_err, bound_err, row0_plots, addr_nz, addr2;

  task automatic run(input int which, input logic [2:0] hole, input logic erase,
                     input logic [11:0] exp_col, input int x0, input int y0, input int budget);
    int last_lin, lin;
    logic p, d;
    logic [7:0] ax, px;
    logic [6:0] py;
    logic [11:0] pc;
    n_plots = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    first_cyc = 0; done_cyc = 0; order_err = 0; colour_err = 0; bound_err = 0;
    row0_plots = 0; addr_nz = 0; addr2 = -1; last_lin = -1;
    @(negedge clk);
    if (which == 0) begin hole_a = hole; erase_a = erase; start_a = 1'b1; end
    else begin hole_b = hole; erase_b = erase; start_b = 1'b1; end
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      p  = which ? plot_b : plot_a;
      d  = which ? done_b : done_a;
      ax = which ? addr_b : addr_a;
      px = which ? x_b : x_a;
      py = which ? y_b : y_a;
      pc = which ? col_b : col_a;
      if (n == 2) addr2 = int'(ax);
      if (ax != 8'd0) addr_nz++;
      if (p) begin
        lin = int'(py) * 256 + int'(px);
        if (n_plots == 0) begin first_x = int'(px); first_y = int'(py); first_cyc = n; end
        else if (lin <= last_lin) order_err++;
        last_lin = lin;
        last_x = int'(px);
        last_y = int'(py);
        if (pc != exp_col) colour_err++;
        if (int'(px) < x0 || int'(px) > x0 + 15 || int'(py) < y0 || int'(py) > y0 + 15) bound_err++;
        if (int'(py) == y0) row0_plots++;
        n_plots++;
      end
      if (d) begin done_cyc = n; break; end
    end
  endtask

  int cnt;

  initial begin
    rst_a = 1'b0; start_a = 1'b0; hole_a = '0; erase_a = 1'b0;
    rst_b = 1'b0; start_b = 1'b0; hole_b = '0; erase_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_plot", plot_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_xyc", {x_a, y_a, col_a}, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);

    rom_mode_a = 0;
    run(0, 3'd0, 1'b0, 12'h00F, 24, 40, 400);
    check("t1_plots", n_plots, 256);
    check("t1_first_x", first_x, 24);
    check("t1_first_y", first_y, 40);
    check("t1_last_x", last_x, 39);
    check("t1_last_y", last_y, 55);
    check("t1_first_cyc", first_cyc, 3);
    check("t1_addr2", addr2, 1);
    check("t1_done_cyc", done_cyc, 259);
    check("t1_order", order_err, 0);
    check("t1_colour", colour_err, 0);
    check("t1_bounds", bound_err, 0);
    @(negedge clk);
    check("t1_idle_busy", busy_a, 0);
    check("t1_done_pulse", done_a, 0);

    run(0, 3'd5, 1'b1, 12'h4A2, 120, 84, 400);
    check("t2_plots", n_plots, 256);
    check("t2_first", first_x * 256 + first_y, 120 * 256 + 84);
    check("t2_last", last_x * 256 + last_y, 135 * 256 + 99);
    check("t2_colour", colour_err, 0);
    check("t2_order", order_err, 0);
    check("t2_bounds", bound_err, 0);
    check("t2_done_cyc", done_cyc, 259);

    rom_mode_a = 1;
    run(0, 3'd1, 1'b0, 12'hFFF, 72, 40, 400);
    check("t3_plots", n_plots, 240);
    check("t3_row0", row0_plots, 0);
    check("t3_first_x", first_x, 72);
    check("t3_first_y", first_y, 41);
    check("t3_colour", colour_err, 0);
    check("t3_order", order_err, 0);
    check("t3_done_cyc", done_cyc, 259);

    rom_mode_a = 0;
    run(0, 3'd7, 1'b0, 12'h00F, 0, 0, 20);
    check("t4_done_cyc", done_cyc, 1);
    check("t4_plots", n_plots, 0);
    check("t4_addr_nz", addr_nz, 0);
    @(negedge clk);
    check("t4_idle_busy", busy_a, 0);

    // Re-pulse during the sweep, then reset once 100 pixels are out.
    cnt = 0; colour_err = 0; bound_err = 0;
    @(negedge clk);
    hole_a = 3'd0; erase_a = 1'b0; start_a = 1'b1;
    for (int n = 1; n <= 400 && cnt < 100; n++) begin
      @(negedge clk);
      start_a = (n == 50);
      if (n == 50) begin hole_a = 3'd5; erase_a = 1'b1; end
      if (plot_a) begin
        cnt++;
        if (col_a != 12'h00F) colour_err++;
        if (x_a < 8'd24 || x_a > 8'd39) bound_err++;
      end
    end
    start_a = 1'b0;
    check("t5_reach100", cnt, 100);
    check("t5_repulse_colour", colour_err, 0);
    check("t5_repulse_bounds", bound_err, 0);
    rst_a = 1'b0;
    #1;
    check("t5_rst_plot", plot_a, 0);
    check("t5_rst_addr", addr_a, 0);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_xyc", {x_a, y_a, col_a}, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (plot_a || busy_a) cnt++;
    end
    check("t5_post_rst_quiet", cnt, 0);
    run(0, 3'd2, 1'b0, 12'h00F, 120, 40, 400);
    check("t5_plots", n_plots, 256);
    check("t5_done_cyc", done_cyc, 259);

    rom_mode_b = 0;
    run(1, 3'd3, 1'b0, 12'h00F, 24, 84, 400);
    check("t6_plots", n_plots, 256);
    check("t6_first_cyc", first_cyc, 4);
    check("t6_first", first_x * 256 + first_y, 24 * 256 + 84);
    check("t6_done_cyc", done_cyc, 260);
    check("t6_order", order_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
